// File: rtl/task1b_if.sv
// Parallel byte request/acknowledge handshake between the slow producer and the UART sender.
interface task1b_if;
    logic t0, t1, t2, t3, t4, t5, t6, t7;
    logic tsent;
    logic trecieve;

    modport master (
        output t0, t1, t2, t3, t4, t5, t6, t7, tsent,
        input  trecieve
    );

    modport slave (
        input  t0, t1, t2, t3, t4, t5, t6, t7, tsent,
        output trecieve
    );
endinterface

// File: rtl/task1b.sv
// UART 8N1 transmitter with level handshake, plus a multiplexed 4-digit hex status display
// (last byte sent, bytes-sent count) that a debounced pushbutton clears.
module task1b #(
    parameter int unsigned BIT_DIV      = 2304,
    parameter int unsigned REFRESH_BITS = 16,
    parameter int unsigned PB_TICK_BITS = 17
) (
    input  logic     clk_raw,
    input  logic     rst_n,
    task1b_if.slave  hs,
    input  logic     pb5_raw,
    output logic     tx,
    output logic     a,
    output logic     b,
    output logic     c,
    output logic     d,
    output logic     e,
    output logic     f,
    output logic     g,
    output logic     numsl0,
    output logic     numsl1,
    output logic     numsl2,
    output logic     numsl3
);
    localparam int unsigned CntW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitLow} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         div_q, div_d;
    logic [2:0]              bit_q, bit_d;
    logic [7:0]              shift_q, shift_d;
    logic [7:0]              last_q, last_d;
    logic [7:0]              count_q, count_d;
    logic                    tx_q, tx_d;
    logic                    ack_q, ack_d;
    logic [1:0]              tsent_ff, pb_ff;
    logic [PB_TICK_BITS-1:0] tick_q;
    logic                    tick_msb_q, pb_sample_q;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic                    tsent_sync, pb_sync;
    logic                    capture, stop_done, bit_end, tick_en, clr;
    logic [7:0]              data_in;
    logic [1:0]              digit_sel;
    logic [3:0]              nibble;
    logic [6:0]              seg;
    logic [3:0]              numsl;

    assign data_in    = {hs.t0, hs.t1, hs.t2, hs.t3, hs.t4, hs.t5, hs.t6, hs.t7};
    assign tsent_sync = tsent_ff[1];
    assign pb_sync    = pb_ff[1];
    assign bit_end    = (div_q == CntW'(BIT_DIV - 1));

    // Button sampled only on rising edges of the tick MSB; a rising sample pair yields one pulse.
    assign tick_en = tick_q[PB_TICK_BITS-1] & ~tick_msb_q;
    assign clr     = tick_en & pb_sync & ~pb_sample_q;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        capture   = 1'b0;
        stop_done = 1'b0;
        if (state_q == StStart || state_q == StData || state_q == StStop) begin
            div_d = bit_end ? '0 : div_q + 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                if (tsent_sync) begin
                    capture = 1'b1;
                    shift_d = data_in;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: if (bit_end) state_d = StData;
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    stop_done = 1'b1;
                    state_d   = StWaitLow;
                end
            end
            StWaitLow: if (!tsent_sync) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // tx is registered from the current state, so the line moves one cycle after capture.
    always_comb begin
        tx_d = 1'b1;
        if (state_q == StStart) tx_d = 1'b0;
        else if (state_q == StData) tx_d = shift_q[0];
    end

    always_comb begin
        ack_d   = capture ? 1'b1 : (tsent_sync ? ack_q : 1'b0);
        last_d  = last_q;
        count_d = count_q;
        if (clr) begin
            last_d  = 8'h00;
            count_d = 8'h00;
        end else begin
            if (capture)   last_d  = data_in;
            if (stop_done) count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_raw or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            div_q       <= '0;
            bit_q       <= '0;
            shift_q     <= 8'h00;
            last_q      <= 8'h00;
            count_q     <= 8'h00;
            tx_q        <= 1'b1;
            ack_q       <= 1'b0;
            tsent_ff    <= 2'b00;
            pb_ff       <= 2'b00;
            tick_q      <= '0;
            tick_msb_q  <= 1'b0;
            pb_sample_q <= 1'b0;
            refresh_q   <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            count_q    <= count_d;
            tx_q       <= tx_d;
            ack_q      <= ack_d;
            tsent_ff   <= {tsent_ff[0], hs.tsent};
            pb_ff      <= {pb_ff[0], pb5_raw};
            tick_q     <= tick_q + 1'b1;
            tick_msb_q <= tick_q[PB_TICK_BITS-1];
            refresh_q  <= refresh_q + 1'b1;
            if (tick_en) pb_sample_q <= pb_sync;
        end
    end

    assign tx          = tx_q;
    assign hs.trecieve = ack_q;

    assign digit_sel = refresh_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        unique case (digit_sel)
            2'd0:    nibble = last_q[3:0];
            2'd1:    nibble = last_q[7:4];
            2'd2:    nibble = count_q[3:0];
            default: nibble = count_q[7:4];
        endcase
    end

    // Active-low segments, bit order {a,b,c,d,e,f,g}.
    always_comb begin
        unique case (nibble)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
    end

    assign {a, b, c, d, e, f, g} = seg;
    assign numsl = ~(4'b0001 << digit_sel);
    assign {numsl3, numsl2, numsl1, numsl0} = numsl;
endmodule

// File: tb/tb_task1b.sv
// Directed bench for task1b: UART framing, handshake, display contents, button clear and reset.
module tb_task1b;
    localparam int unsigned BitDiv = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb5_raw = 1'b0;
    logic tx, a, b, c, d, e, f, g;
    logic numsl0, numsl1, numsl2, numsl3;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    task1b_if hs ();

    task1b #(
        .BIT_DIV      (BitDiv),
        .REFRESH_BITS (3),
        .PB_TICK_BITS (3)
    ) dut (
        .clk_raw (clk),
        .rst_n   (rst_n),
        .hs      (hs),
        .pb5_raw (pb5_raw),
        .tx      (tx),
        .a       (a),
        .b       (b),
        .c       (c),
        .d       (d),
        .e       (e),
        .f       (f),
        .g       (g),
        .numsl0  (numsl0),
        .numsl1  (numsl1),
        .numsl2  (numsl2),
        .numsl3  (numsl3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] font(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic check_display(input string tag, input logic [7:0] last, input logic [7:0] cnt);
        logic [6:0] seen [4];
        logic [3:0] mask;
        logic [3:0] ns;
        bit         hot_ok, order_ok;
        int         prev, idx;
        mask = '0; hot_ok = 1'b1; order_ok = 1'b1; prev = -1;
        for (int k = 0; k < 12; k++) begin
            ns  = {numsl3, numsl2, numsl1, numsl0};
            idx = -1;
            case (ns)
                4'b1110: idx = 0;
                4'b1101: idx = 1;
                4'b1011: idx = 2;
                4'b0111: idx = 3;
                default: hot_ok = 1'b0;
            endcase
            if (idx >= 0) begin
                seen[idx] = {a, b, c, d, e, f, g};
                mask[idx] = 1'b1;
                if (prev >= 0 && idx != prev && idx != (prev + 1) % 4) order_ok = 1'b0;
                prev = idx;
            end
            @(negedge clk);
        end
        check_eq({tag, ".onehot"}, 64'(hot_ok), 64'd1);
        check_eq({tag, ".order"}, 64'(order_ok), 64'd1);
        check_eq({tag, ".alldigits"}, 64'(mask), 64'hF);
        check_eq({tag, ".d0"}, 64'(seen[0]), 64'(font(last[3:0])));
        check_eq({tag, ".d1"}, 64'(seen[1]), 64'(font(last[7:4])));
        check_eq({tag, ".d2"}, 64'(seen[2]), 64'(font(cnt[3:0])));
        check_eq({tag, ".d3"}, 64'(seen[3]), 64'(font(cnt[7:4])));
    endtask

    task automatic start_req(input logic [7:0] data);
        {hs.t0, hs.t1, hs.t2, hs.t3, hs.t4, hs.t5, hs.t6, hs.t7} = data;
        hs.tsent = 1'b1;
    endtask

    task automatic wait_ack(input string tag, input logic lvl, output int n);
        n = 0;
        while (hs.trecieve !== lvl && n < 8) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, 64'(hs.trecieve), 64'(lvl));
    endtask

    // Records 40 cycles from the start bit; each bit must last exactly BitDiv cycles.
    task automatic check_frame(input string tag, input logic [7:0] data);
        logic [39:0] got, exp;
        int          n, bitn;
        n = 0;
        while (tx !== 1'b0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (tx !== 1'b0) begin
            check_eq({tag, ".start_timeout"}, 64'(tx), 64'd0);
        end else begin
            for (int k = 0; k < 40; k++) begin
                bitn   = k / BitDiv;
                exp[k] = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : data[bitn-1];
                got[k] = tx;
                @(negedge clk);
            end
            check_eq(tag, 64'(got), 64'(exp));
        end
    endtask

    task automatic end_req(input string tag);
        int n;
        hs.tsent = 1'b0;
        wait_ack({tag, ".ack_fall"}, 1'b0, n);
        repeat (3) @(negedge clk);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] data, input bit chk);
        int n;
        start_req(data);
        wait_ack({tag, ".ack"}, 1'b1, n);
        if (chk) begin
            check_eq({tag, ".ack_lat"}, 64'(n <= 3), 64'd1);
            check_frame({tag, ".frame"}, data);
        end else begin
            repeat (44) @(negedge clk);
        end
        end_req(tag);
    endtask

    initial begin
        int          n, lows;
        logic [7:0]  v;
        hs.tsent = 1'b0;
        {hs.t0, hs.t1, hs.t2, hs.t3, hs.t4, hs.t5, hs.t6, hs.t7} = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("reset.tx", 64'(tx), 64'd1);
        check_eq("reset.ack", 64'(hs.trecieve), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_display("reset.disp", 8'h00, 8'h00);

        send_byte("b41", 8'h41, 1'b1);
        check_display("b41.disp", 8'h41, 8'h01);

        // Request held for three frame times: one frame only.
        start_req(8'h5A);
        wait_ack("held.ack", 1'b1, n);
        check_frame("held.frame", 8'h5A);
        lows = 0;
        for (int k = 0; k < 120; k++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        check_eq("held.no_second_frame", 64'(lows), 64'd0);
        check_eq("held.ack_stays", 64'(hs.trecieve), 64'd1);
        end_req("held");
        check_display("held.disp", 8'h5A, 8'h02);

        send_byte("seq41", 8'h41, 1'b1);
        send_byte("seq42", 8'h42, 1'b1);
        send_byte("seq43", 8'h43, 1'b1);
        check_display("seq.disp", 8'h43, 8'h05);

        // 251 more sends bring the count to 256, i.e. wraps to 0x00.
        for (int i = 0; i < 251; i++) begin
            v = 8'(i);
            send_byte("wrap", v, 1'b0);
        end
        check_display("wrap.disp", 8'hFA, 8'h00);

        // Button pressed mid-frame clears state; the frame and its STOP increment still happen.
        start_req(8'h3C);
        wait_ack("btn.ack", 1'b1, n);
        fork
            check_frame("btn.frame", 8'h3C);
            begin
                repeat (4) @(negedge clk);
                pb5_raw = 1'b1;
                repeat (12) @(negedge clk);
                check_display("btn.mid", 8'h00, 8'h00);
                repeat (24) @(negedge clk);
                pb5_raw = 1'b0;
            end
        join
        end_req("btn");
        check_display("btn.after", 8'h00, 8'h01);

        pb5_raw = 1'b1;
        repeat (40) @(negedge clk);
        pb5_raw = 1'b0;
        repeat (10) @(negedge clk);
        check_display("repress.disp", 8'h00, 8'h00);

        send_byte("b77", 8'h77, 1'b1);
        check_display("b77.disp", 8'h77, 8'h01);

        // One-cycle glitch placed well away from the button sampling edge.
        while (cyc % 8 != 0) @(negedge clk);
        pb5_raw = 1'b1;
        @(negedge clk);
        pb5_raw = 1'b0;
        repeat (30) @(negedge clk);
        check_display("glitch.disp", 8'h77, 8'h01);

        // Reset mid-frame aborts the frame at once.
        start_req(8'h00);
        wait_ack("rstmid.ack", 1'b1, n);
        repeat (10) @(negedge clk);
        check_eq("rstmid.tx_busy", 64'(tx), 64'd0);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid.tx", 64'(tx), 64'd1);
        check_eq("rstmid.ack", 64'(hs.trecieve), 64'd0);
        hs.tsent = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int k = 0; k < 50; k++) begin
            if (tx !== 1'b1) lows++;
            @(negedge clk);
        end
        check_eq("rstmid.idle", 64'(lows), 64'd0);
        check_display("rstmid.disp", 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/task1b.md
Name: task1b

Overview:
- UART 8N1 transmitter with a level request/acknowledge handshake on an 8-bit parallel input.
- Multiplexed 4-digit 7-segment status display: last byte sent, and count of bytes sent.
- Pushbutton pb5 clears the display state.
- Sits between a slow producer domain (driving t0..t7/tsent) and the board's serial TX pin and LED display.

Parameters:
- BIT_DIV, 2304, clk_raw cycles per UART bit (22.1184 MHz / 9600 baud).
- REFRESH_BITS, 16, width of the display refresh counter; its top 2 bits select the active digit.
- PB_TICK_BITS, 17, width of the button sampling counter; its MSB is the button sample clock-enable edge.

Ports:
- clk_raw  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a,b,c,d,e,f,g  out  1 each  segment drives, active-low (0 = segment lit).
- numsl0..numsl3  out  1 each  digit enables, active-low, exactly one low at a time; numsl0 = rightmost digit.
- tx  out  1  UART serial output, idle high.
- pb5_raw  in  1  raw asynchronous pushbutton, active-high.
- t0..t7  in  1 each  parallel data byte; t0 = bit7 (MSB), t7 = bit0 (LSB).
- tsent  in  1  send request (level), asynchronous to clk_raw.
- trecieve  out  1  acknowledge (level).

Behaviour:
- Reset (async, rst_n=0):
  - tx=1, trecieve=0, FSM=IDLE.
  - Bit/refresh/tick counters = 0.
  - last_byte=8'h00, sent_count=8'h00.
  - Display shows "0000".
- Synchronisers:
  - tsent and pb5_raw each pass through a 2-FF synchroniser before use.
  - t0..t7 are sampled only at capture, when tsent_sync=1, so they are stable.
- Handshake / FSM, states IDLE, START, DATA, STOP, WAITLOW:
  - IDLE: when tsent_sync=1:
    - latch shift_reg={t0..t7} and set last_byte to the same value;
    - set trecieve=1;
    - go to START.
  - START: tx=0 for BIT_DIV cycles.
  - DATA: 8 bits, LSB (t7) first, each held BIT_DIV cycles.
  - STOP: tx=1 for BIT_DIV cycles; then sent_count <= sent_count+1 (wraps 8'hFF->8'h00); go to WAITLOW.
  - WAITLOW: when tsent_sync=0, clear trecieve and go to IDLE.
  - trecieve also clears as soon as tsent_sync=0 in any state, but a new byte is never accepted before WAITLOW->IDLE completes. A request held high across frames therefore yields exactly one frame.
  - Frame length is exactly 10*BIT_DIV cycles. The tx edge occurs 1 cycle after the capture edge.
- Button:
  - pb5_sync is sampled on each 0->1 transition of the tick counter MSB.
  - A 0->1 change between consecutive samples produces a single-cycle pulse clr.
  - Holding the button produces only one pulse.
  - clr sets last_byte=0 and sent_count=0. The frame in flight continues unaffected.
  - If clr coincides with the STOP increment, clr wins (count=0).
- Display:
  - The refresh counter free-runs; digit index = counter[REFRESH_BITS-1:REFRESH_BITS-2].
  - digit0 = last_byte[3:0], digit1 = last_byte[7:4], digit2 = sent_count[3:0], digit3 = sent_count[7:4].
  - Hex font 0-9, A, b, C, d, E, F. Segment order a..g standard.
  - Example: "0" = a..f lit, g off → a..g = 0000001. "1" = b,c lit → 1001111.
- Reset mid-frame aborts immediately: tx=1, FSM=IDLE.

Test Plan:
- Reset: rst_n low → tx=1, trecieve=0, display digits all "0" (segments 0000001), one numsl low and cycling in order 0,1,2,3.
- Send 0x41 (BIT_DIV=4): {t0..t7}=01000001, tsent=1 → trecieve=1 within 3 cycles. tx: start 0, then bits 1,0,0,0,0,0,1,0, stop 1, each exactly 4 cycles. Drop tsent → trecieve=0. Digits: 0="1", 1="4", 2="1", 3="0".
- Held request: tsent kept high for 3 frame times → exactly one frame on tx; count stays 1.
- Incrementing sequence 0x41,0x42,0x43 with full handshake each → three frames with correct LSB-first bits; last_byte=0x43, count=3.
- Count wrap: 256 handshaked sends → sent_count=0x00.
- Button (PB_TICK_BITS=3): pb5_raw high for 40 cycles mid-frame → last_byte and count cleared once, frame on tx completes intact; re-press → cleared again; glitch shorter than one tick → no effect.
